// File: rtl/cpu_pkg.sv
// Shared encodings for the Phase 2 controller: opcodes, state codes, strobe bundle
// and the instruction-class helpers used by both decode and next-state logic.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        ST_RESET = 4'b0000,
        ST_T0    = 4'b0001,
        ST_T1    = 4'b0010,
        ST_T2    = 4'b0011,
        ST_T3    = 4'b0100,
        ST_T4    = 4'b0101,
        ST_T5    = 4'b0110,
        ST_T6    = 4'b0111,
        ST_T7    = 4'b1000,
        ST_HALT  = 4'b1111
    } state_t;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic inport_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic zlow_in;
        logic zhigh_in;
        logic hi_in;
        logic lo_in;
        logic r_in;
        logic con_in;
        logic outport_in;
        logic inc_pc;
        logic read;
        logic ram_in;
        logic gra;
        logic grb;
        logic grc;
    } strobes_t;

    function automatic logic is_alu_r(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    // ldi shares the immediate datapath; it only swaps Rout for BAout in T3
    function automatic logic is_imm(input logic [4:0] op);
        return ((op >= OP_ADDI) && (op <= OP_ORI)) || (op == OP_LDI);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic state_t final_step(input logic [4:0] op);
        if (is_alu_r(op) || is_imm(op))        return ST_T5;
        else if (is_mem(op))                   return ST_T7;
        else if (op == OP_MUL || op == OP_DIV) return ST_T6;
        else if (op == OP_NEG || op == OP_NOT) return ST_T4;
        else if (op == OP_BR)                  return ST_T6;
        else                                   return ST_T3;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational map from {state, opcode, CON} to the full strobe bundle.
// States the FSM never reaches for a given opcode decode to all-zero.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con,
    output strobes_t   s
);

    always_comb begin
        s = '0;
        case (state)
            ST_T0: begin
                s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.zlow_in = 1'b1;
            end
            ST_T1: begin
                s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1;
            end
            ST_T2: begin
                s.mdr_out = 1'b1; s.ir_in = 1'b1;
            end
            ST_T3: begin
                if (is_alu_r(opcode) || is_imm(opcode) || is_mem(opcode)) begin
                    s.grb = 1'b1; s.y_in = 1'b1;
                    if (is_mem(opcode) || opcode == OP_LDI) s.ba_out = 1'b1;
                    else                                    s.r_out  = 1'b1;
                end else if (opcode == OP_MUL || opcode == OP_DIV) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1;
                end else if (opcode == OP_NEG || opcode == OP_NOT) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1;
                end else if (opcode == OP_BR) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1;
                end else if (opcode == OP_JR) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1;
                end else if (opcode == OP_IN) begin
                    s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (opcode == OP_OUT) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1;
                end else if (opcode == OP_MFHI) begin
                    s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (opcode == OP_MFLO) begin
                    s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end
            end
            ST_T4: begin
                if (is_alu_r(opcode)) begin
                    s.grc = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1;
                end else if (is_imm(opcode) || is_mem(opcode)) begin
                    s.c_out = 1'b1; s.zlow_in = 1'b1;
                end else if (opcode == OP_MUL || opcode == OP_DIV) begin
                    s.grb = 1'b1; s.r_out = 1'b1; s.zlow_in = 1'b1; s.zhigh_in = 1'b1;
                end else if (opcode == OP_NEG || opcode == OP_NOT) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (opcode == OP_BR) begin
                    s.pc_out = 1'b1; s.y_in = 1'b1;
                end
            end
            ST_T5: begin
                if (is_alu_r(opcode) || is_imm(opcode)) begin
                    s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (is_mem(opcode)) begin
                    s.zlow_out = 1'b1; s.mar_in = 1'b1;
                end else if (opcode == OP_MUL || opcode == OP_DIV) begin
                    s.zlow_out = 1'b1; s.lo_in = 1'b1;
                end else if (opcode == OP_BR) begin
                    s.c_out = 1'b1; s.zlow_in = 1'b1;
                end
            end
            ST_T6: begin
                if (opcode == OP_LD) begin
                    s.read = 1'b1; s.mdr_in = 1'b1;
                end else if (opcode == OP_ST) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1;
                end else if (opcode == OP_MUL || opcode == OP_DIV) begin
                    s.zhigh_out = 1'b1; s.hi_in = 1'b1;
                end else if (opcode == OP_BR) begin
                    s.zlow_out = con; s.pc_in = con;
                end
            end
            ST_T7: begin
                if (opcode == OP_LD) begin
                    s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end else if (opcode == OP_ST) begin
                    s.ram_in = 1'b1;
                end
            end
            default: s = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Phase 2 datapath: state register, next-state
// logic with halt/stop handling, and fan-out of the decoded strobe bundle.
module control_unit
    import cpu_pkg::*;
(
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] opcode,
    input  logic       CON,
    input  logic       Stop,
    output logic       PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortOut,
    output logic       PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn,
    output logic       IncPC, Read, RAMin,
    output logic       GRA, GRB, GRC,
    output logic       Run,
    output logic [3:0] Tstate
);

    state_t   state, state_next;
    strobes_t s;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= ST_RESET;
        else        state <= state_next;
    end

    // Stop is only honoured on the edge leaving an instruction's last step
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_T0;
            ST_HALT:  state_next = ST_HALT;
            default: begin
                if (state == final_step(opcode))
                    state_next = (opcode == OP_HALT || Stop) ? ST_HALT : ST_T0;
                else
                    state_next = state_t'(state + 4'd1);
            end
        endcase
    end

    ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .con    (CON),
        .s      (s)
    );

    assign {PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, BAout, Rout, InPortOut,
            PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn,
            IncPC, Read, RAMin, GRA, GRB, GRC} = s;

    assign Run    = (state != ST_HALT);
    assign Tstate = state;

endmodule
